mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register: issues loads/stores to data memory over a
//  req/ack handshake and stalls the pipe while an access is outstanding. Registers the MEM/WB
//  payload (ALU result, load data, RD, WB controls). Misaligned or timed-out accesses become bubbles
//  and raise an error pulse.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles dmem_req may wait for dmem_ack before abort (>=1)
//  CNT_W           5   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock          in   1   clock
//  reset          in   1   reset, asynchronous, active-high
//  MEM_RegWrite   in   1   EX/MEM: instruction writes a register
//  MEM_MemToReg   in   1   EX/MEM: WB selects load data
//  MEM_MEM_WREN   in   1   EX/MEM: store
//  MEM_MEM_RDEN   in   1   EX/MEM: load
//  MEM_ALUResult  in   32  EX/MEM: effective address / ALU result
//  MEM_WriteData  in   32  EX/MEM: store data
//  MEM_RD         in   5   EX/MEM: destination register
//  dmem_req       out  1   access request, held until dmem_ack or abort
//  dmem_wren      out  1   request is a write
//  dmem_addr      out  32  word address (byte address, [1:0]=0)
//  dmem_wdata     out  32  store data
//  dmem_ack       in   1   memory done; dmem_rdata valid same cycle for reads
//  dmem_rdata     in   32  load data
//  mem_stall      out  1   hold PC/IF_ID/ID_EX/EX_MEM this cycle
//  mem_err        out  1   1-cycle pulse: misaligned or timeout
//  WB_RegWrite, WB_MemToReg  out 1 each;  WB_ALUResult, WB_ReadData  out 32 each;  WB_RD  out 5
// BEHAVIOUR
//  - Reset (async): state IDLE, counter 0, all outputs 0; dmem_req drops immediately mid-access.
//  - access = MEM_MEM_RDEN | MEM_MEM_WREN; if both set, treated as write (read ignored).
//  - States: IDLE, WAIT, DONE.
//    IDLE: access & MEM_ALUResult[1:0]==0 -> register addr/wdata/wren, go WAIT. mem_stall=1 this
//      cycle (combinational). Misaligned access -> stay IDLE, no request, mem_err=1, WB bubble,
//      mem_stall=0. No access -> pass-through.
//    WAIT: dmem_req=1, addr/wdata/wren stable. dmem_ack -> capture dmem_rdata, go DONE.
//      Else counter++; counter==TIMEOUT_CYCLES-1 without ack -> drop req, mem_err=1, set abort
//      flag, go DONE. mem_stall=1 throughout WAIT. Ack in the timeout cycle counts as success.
//    DONE: mem_stall=0 (EX/MEM advances); no new request even though inputs still show the access;
//      WB loads the completed instruction (bubble if aborted). Next state IDLE, counter cleared.
//  - mem_stall = (IDLE & access & aligned) | WAIT. Memory latency N ack-cycles -> N+1 stall cycles.
//  - WB registers, every cycle:
//    mem_stall=1 -> bubble: WB_RegWrite=0, WB_MemToReg=0, WB_RD=0, data 0.
//    else -> WB_RegWrite/MemToReg/RD/ALUResult from MEM_*; WB_ReadData = captured load data
//      (0 for non-loads). Misaligned or aborted -> bubble.
//  - Non-memory instructions: 1-cycle latency to WB, never stall.
//  - Stores write no register from the memory path; WB_RegWrite follows MEM_RegWrite.
//  - dmem_req never asserts in IDLE or DONE; at most one outstanding access.
// TESTING
//  - ALU op, RD=5, ALUResult=0x1234 -> next cycle WB_RD=5, WB_ALUResult=0x1234, mem_stall never 1.
//  - Load addr 0x40, ack after 3 cycles, rdata 0xDEADBEEF -> mem_stall 4 cycles, then
//    WB_ReadData=0xDEADBEEF, WB_MemToReg=1.
//  - Store addr 0x44 data 0xA5A5A5A5, ack 1st WAIT cycle -> dmem_wren=1, addr/wdata stable, 2 stalls.
//  - Load addr 0x42 -> no dmem_req, mem_err 1 cycle, WB_RegWrite=0, no stall.
//  - Load, ack never -> req high 16 cycles, mem_err pulse, WB bubble, pipe resumes.
//  - Reset asserted in WAIT -> dmem_req=0 and mem_stall=0 async; after release, new load completes.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_ctrl_if;
  logic        req;
  logic        wren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output wren, output addr, output wdata,
                  input ack, input rdata);
  modport slave  (input req, input wren, input addr, input wdata,
                  output ack, output rdata);
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one outstanding data-memory access at a time, stalls the pipe while it
// is in flight, and registers the MEM/WB payload. Misaligned/timed-out accesses become bubbles.
//
// state   | meaning
// IDLE    | no access in flight; launches an aligned access, flags a misaligned one
// WAIT    | request held on the bus until ack or timeout
// DONE    | access finished; EX/MEM advances and WB takes the result
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    MEM_RegWrite,
  input  logic                    MEM_MemToReg,
  input  logic                    MEM_MEM_WREN,
  input  logic                    MEM_MEM_RDEN,
  input  logic [31:0]             MEM_ALUResult,
  input  logic [31:0]             MEM_WriteData,
  input  logic [4:0]              MEM_RD,
  mem_stage_ctrl_if.master        dmem,
  output logic                    mem_stall,
  output logic                    mem_err,
  output logic                    WB_RegWrite,
  output logic                    WB_MemToReg,
  output logic [31:0]             WB_ALUResult,
  output logic [31:0]             WB_ReadData,
  output logic [4:0]              WB_RD
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             aborted;
  logic [31:0]      rdata_q;

  logic access;
  logic aligned;
  logic is_load;
  logic stall_req;
  logic bubble;

  assign access    = MEM_MEM_RDEN | MEM_MEM_WREN;
  assign aligned   = (MEM_ALUResult[1:0] == 2'b00);
  // A simultaneous read+write request is treated as a pure store.
  assign is_load   = MEM_MEM_RDEN & ~MEM_MEM_WREN;
  assign stall_req = ((state == ST_IDLE) & access & aligned) | (state == ST_WAIT);
  assign mem_stall = stall_req & ~reset;
  assign bubble    = stall_req
                   | ((state == ST_IDLE) & access & ~aligned)
                   | ((state == ST_DONE) & aborted);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      aborted      <= 1'b0;
      rdata_q      <= '0;
      dmem.req     <= 1'b0;
      dmem.wren    <= 1'b0;
      dmem.addr    <= '0;
      dmem.wdata   <= '0;
      mem_err      <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
      WB_ALUResult <= '0;
      WB_ReadData  <= '0;
      WB_RD        <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && aligned) begin
            dmem.req   <= 1'b1;
            dmem.wren  <= MEM_MEM_WREN;
            dmem.addr  <= MEM_ALUResult;
            dmem.wdata <= MEM_WriteData;
            cnt        <= '0;
            aborted    <= 1'b0;
            state      <= ST_WAIT;
          end else if (access) begin
            mem_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Ack wins over the timeout when both land in the same cycle.
          if (dmem.ack) begin
            rdata_q  <= dmem.rdata;
            dmem.req <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dmem.req <= 1'b0;
            mem_err  <= 1'b1;
            aborted  <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (bubble) begin
        WB_RegWrite  <= 1'b0;
        WB_MemToReg  <= 1'b0;
        WB_ALUResult <= '0;
        WB_ReadData  <= '0;
        WB_RD        <= '0;
      end else begin
        WB_RegWrite  <= MEM_RegWrite;
        WB_MemToReg  <= MEM_MemToReg;
        WB_ALUResult <= MEM_ALUResult;
        WB_ReadData  <= ((state == ST_DONE) && is_load) ? rdata_q : 32'h0;
        WB_RD        <= MEM_RD;
      end
    end
  end

endmodule
